// File: rtl/fp_special_pipe.sv
// Stage 1 of the shared FP add/mul datapath: special-value classification
// with a 2-entry skid buffer so in_ready comes straight from a flop.
`ifndef FP_SPECIAL_DEFS
`define FP_SPECIAL_DEFS
`define FP16 0
`define FP32 1
`define FP64 2
`define GET_FP_LEN(f) ((f) == `FP16 ? 16 : (f) == `FP64 ? 64 : 32)
`define GET_EXP_LEN(f) ((f) == `FP16 ? 5 : (f) == `FP64 ? 11 : 8)
`define GET_MAN_LEN(f) ((f) == `FP16 ? 10 : (f) == `FP64 ? 52 : 23)
`define NORMAL 2'b00
`define ZERO 2'b01
`define INF 2'b10
`define NAN 2'b11
`endif

module fp_special_pipe #(
  parameter int data_format = `FP32,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [`GET_FP_LEN(data_format)-1:0] in_a,
  input  logic [`GET_FP_LEN(data_format)-1:0] in_b,
  input  logic [1:0] in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic out_valid,
  input  logic out_ready,
  output logic [1:0] out_special,
  output logic [`GET_FP_LEN(data_format)-1:0] out_result,
  output logic out_invalid,
  output logic [`GET_FP_LEN(data_format)-1:0] out_a,
  output logic [`GET_FP_LEN(data_format)-1:0] out_b,
  output logic [1:0] out_op,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W  = `GET_FP_LEN(data_format);
  localparam int EW = `GET_EXP_LEN(data_format);
  localparam int MW = `GET_MAN_LEN(data_format);

  typedef struct packed {
    logic [1:0]       sp;
    logic [W-1:0]     res;
    logic             inv;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  logic          a_s, b_s;
  logic [EW-1:0] a_e, b_e;
  logic [MW-1:0] a_m, b_m;

  assign {a_s, a_e, a_m} = in_a;
  assign {b_s, b_e, b_m} = in_b;

  logic a_nan, b_nan, a_snan, b_snan;
  logic a_inf, b_inf, a_zero, b_zero;
  logic is_mul, sb_eff;

  assign a_nan  = (&a_e) && (|a_m);
  assign b_nan  = (&b_e) && (|b_m);
  assign a_snan = a_nan && !a_m[MW-1];
  assign b_snan = b_nan && !b_m[MW-1];
  assign a_inf  = (&a_e) && !(|a_m);
  assign b_inf  = (&b_e) && !(|b_m);
  assign a_zero = !(|in_a[W-2:0]);
  assign b_zero = !(|in_b[W-2:0]);
  assign is_mul = (in_op == 2'b10);
  assign sb_eff = b_s ^ (in_op == 2'b01);

  logic [1:0]   cls_sp;
  logic         cls_sgn;
  logic         cls_inv;
  logic [W-1:0] cls_res;

  always_comb begin
    cls_sp  = `NORMAL;
    cls_sgn = 1'b0;
    cls_inv = a_snan | b_snan;
    if (a_nan || b_nan) begin
      cls_sp = `NAN;
    end else if (is_mul) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        cls_sp  = `NAN;
        cls_inv = 1'b1;
      end else if (a_inf || b_inf) begin
        cls_sp  = `INF;
        cls_sgn = a_s ^ b_s;
      end else if (a_zero || b_zero) begin
        cls_sp  = `ZERO;
        cls_sgn = a_s ^ b_s;
      end
    end else begin
      if (a_inf && b_inf) begin
        if (a_s == sb_eff) begin
          cls_sp  = `INF;
          cls_sgn = a_s;
        end else begin
          cls_sp  = `NAN;
          cls_inv = 1'b1;
        end
      end else if (a_inf) begin
        cls_sp  = `INF;
        cls_sgn = a_s;
      end else if (b_inf) begin
        cls_sp  = `INF;
        cls_sgn = sb_eff;
      end else if (a_zero && b_zero) begin
        cls_sp  = `ZERO;
        cls_sgn = a_s & sb_eff;
      end
    end
  end

  always_comb begin
    cls_res = '0;
    unique case (cls_sp)
      `NAN:    cls_res = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      `INF:    cls_res = {cls_sgn, {EW{1'b1}}, {MW{1'b0}}};
      `ZERO:   cls_res = {cls_sgn, {(W-1){1'b0}}};
      default: cls_res = '0;
    endcase
  end

  ent_t new_e;

  always_comb begin
    new_e     = '0;
    new_e.sp  = cls_sp;
    new_e.res = cls_res;
    new_e.inv = cls_inv;
    new_e.a   = in_a;
    new_e.b   = in_b;
    new_e.op  = in_op;
    new_e.tag = in_tag;
  end

  state_t state_q;
  ent_t   main_q;
  ent_t   skid_q;
  logic   in_ready_q;

  logic accept, pop, to_two;

  assign accept = in_valid && in_ready_q;
  assign pop    = (state_q != S_EMPTY) && out_ready;
  assign to_two = (state_q == S_ONE && accept && !pop) ||
                  (state_q == S_TWO && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= !to_two;
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_q  <= new_e;
            state_q <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_q <= new_e;
          end else if (accept) begin
            skid_q  <= new_e;
            state_q <= S_TWO;
          end else if (pop) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != S_EMPTY);
  assign out_special = main_q.sp;
  assign out_result  = main_q.res;
  assign out_invalid = main_q.inv;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_op      = main_q.op;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Bench for fp_special_pipe: directed special cases, handshake scenarios
// and randomized traffic against a reference classifier.
module tb_fp_special_pipe;

  localparam logic [1:0] C_NORMAL = 2'b00;
  localparam logic [1:0] C_ZERO   = 2'b01;
  localparam logic [1:0] C_INF    = 2'b10;
  localparam logic [1:0] C_NAN    = 2'b11;

  localparam int NV = 12;
  localparam logic [31:0] VA [NV] = '{
    32'h7F800000, 32'h7F800000, 32'h80000000, 32'h80000000,
    32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800001,
    32'h00000000, 32'hFF800000, 32'hFF800000, 32'h7F800000};
  localparam logic [31:0] VB [NV] = '{
    32'hFF800000, 32'hFF800000, 32'h80000000, 32'h00000000,
    32'h80000000, 32'h80000000, 32'h40000000, 32'h3F800000,
    32'h00000000, 32'h3F800000, 32'h3F800000, 32'hFF800000};
  localparam logic [1:0] VOP [NV] = '{
    2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10,
    2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
  localparam logic [1:0] VSP [NV] = '{
    C_NAN, C_INF, C_ZERO, C_ZERO, C_NAN, C_ZERO,
    C_NORMAL, C_NAN, C_ZERO, C_INF, C_INF, C_NAN};
  localparam logic [31:0] VRES [NV] = '{
    32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000,
    32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7FC00000,
    32'h00000000, 32'hFF800000, 32'hFF800000, 32'h7FC00000};
  localparam logic VINV [NV] = '{
    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_special;
  logic [31:0] out_result;
  logic        out_invalid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [1:0]  out_op;
  logic [3:0]  out_tag;

  fp_special_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_special(out_special), .out_result(out_result),
    .out_invalid(out_invalid), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_tag(out_tag)
  );

  typedef struct {
    logic [1:0]  sp;
    logic [31:0] res;
    logic        inv;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
  } inp_t;

  obs_t got[$];
  inp_t acc[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transfers are observed mid-cycle; inputs only move just after posedge.
  always @(negedge clk) begin
    obs_t o;
    inp_t p;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        o.sp = out_special; o.res = out_result; o.inv = out_invalid;
        o.a = out_a; o.b = out_b; o.op = out_op; o.tag = out_tag;
        o.cyc = cyc;
        got.push_back(o);
      end
      if (in_valid && in_ready && !flush) begin
        p.a = in_a; p.b = in_b; p.op = in_op; p.tag = in_tag;
        acc.push_back(p);
      end
    end
  end

  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0] op);
    logic an, bn, ai, bi, az, bz, inv, sbe, s;
    logic [1:0]  sp;
    logic [31:0] r;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az  = (a[30:0] == 0);
    bz  = (b[30:0] == 0);
    inv = (an && !a[22]) || (bn && !b[22]);
    sbe = b[31] ^ (op == 2'b01);
    sp  = C_NORMAL;
    s   = 1'b0;
    if (an || bn) sp = C_NAN;
    else if (op == 2'b10) begin
      if ((ai && bz) || (az && bi)) begin sp = C_NAN; inv = 1'b1; end
      else if (ai || bi) begin sp = C_INF; s = a[31] ^ b[31]; end
      else if (az || bz) begin sp = C_ZERO; s = a[31] ^ b[31]; end
    end else begin
      if (ai && bi) begin
        if (a[31] == sbe) begin sp = C_INF; s = sbe; end
        else begin sp = C_NAN; inv = 1'b1; end
      end
      else if (ai) begin sp = C_INF; s = a[31]; end
      else if (bi) begin sp = C_INF; s = sbe; end
      else if (az && bz) begin sp = C_ZERO; s = a[31] & sbe; end
    end
    case (sp)
      C_NAN:   r = 32'h7FC00000;
      C_INF:   r = {s, 8'hFF, 23'h0};
      C_ZERO:  r = {s, 31'h0};
      default: r = 32'h0;
    endcase
    return {sp, inv, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 11))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'h7F800001;
      6: return 32'hFFA00000;
      7: return 32'h00000001;
      8: return 32'h3F800000;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({out_special, out_result, out_invalid, out_a, out_b, out_op, out_tag} !== '0)
      $display("FAIL rst_data got res=%h a=%h b=%h tag=%h want 0",
               out_result, out_a, out_b, out_tag);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_special();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_a = VA[i]; in_b = VB[i]; in_op = VOP[i]; in_tag = 4'(i);
      in_valid = 1'b1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL sp%0d_ready got %b want 1", i, in_ready);
      else pass_cnt++;
      tick();
      in_valid = 1'b0;
      chk_cnt++;
      if (out_valid !== 1'b1) $display("FAIL sp%0d_latency out_valid got %b want 1", i, out_valid);
      else pass_cnt++;
      chk_cnt++;
      if ({out_special, out_invalid, out_result} !== {VSP[i], VINV[i], VRES[i]})
        $display("FAIL sp%0d got sp=%0d inv=%b res=%h want sp=%0d inv=%b res=%h",
                 i, out_special, out_invalid, out_result, VSP[i], VINV[i], VRES[i]);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL sp%0d_pop out_valid got %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    got.delete(); acc.delete();
    out_ready = 1'b0;
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 2'b00;
    in_valid = 1'b1; in_tag = 4'd1;
    tick();
    in_tag = 4'd2;
    tick();
    in_tag = 4'd3;
    chk_cnt++;
    if (in_ready !== 1'b0 || out_tag !== 4'd1)
      $display("FAIL bp_full got ready=%b tag=%0d want ready=0 tag=1", in_ready, out_tag);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1)
        $display("FAIL bp_hold%0d got ready=%b valid=%b tag=%0d want 0 1 1",
                 i, in_ready, out_valid, out_tag);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc.size() >= 3) in_valid = 1'b0;
      if (got.size() >= 3) break;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if (got.size() != 3) $display("FAIL bp_count got %0d want 3", got.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      chk_cnt++;
      if (got[i].tag !== 4'(i + 1))
        $display("FAIL bp_order%0d got tag %0d want %0d", i, got[i].tag, i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_throughput();
    int lows;
    int gaps;
    logic [34:0] e;
    got.delete(); acc.delete();
    lows = 0;
    gaps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_a = pick(); in_b = pick(); in_op = 2'($urandom_range(0, 3));
      in_tag = 4'(i); in_valid = 1'b1;
      if (in_ready !== 1'b1) lows++;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk_cnt++;
    if (lows != 0) $display("FAIL tp_ready got %0d stalls want 0", lows);
    else pass_cnt++;
    chk_cnt++;
    if (got.size() != 16 || acc.size() != 16)
      $display("FAIL tp_count got %0d/%0d want 16", got.size(), acc.size());
    else pass_cnt++;
    for (int i = 1; i < got.size(); i++)
      if (got[i].cyc != got[0].cyc + i) gaps++;
    chk_cnt++;
    if (gaps != 0) $display("FAIL tp_consecutive got %0d gaps want 0", gaps);
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < acc.size(); i++) begin
      e = model(acc[i].a, acc[i].b, acc[i].op);
      chk_cnt++;
      if ({got[i].sp, got[i].inv, got[i].res} !== e || got[i].tag !== 4'(i))
        $display("FAIL tp%0d got %h tag %0d want %h tag %0d",
                 i, {got[i].sp, got[i].inv, got[i].res}, got[i].tag, e, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [34:0] e;
    got.delete(); acc.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = pick(); in_b = pick(); in_op = 2'($urandom_range(0, 3));
      in_tag = 4'($urandom());
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk_cnt++;
    if (got.size() != acc.size() || got.size() == 0)
      $display("FAIL rnd_count got %0d want %0d", got.size(), acc.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < acc.size(); i++) begin
      e = model(acc[i].a, acc[i].b, acc[i].op);
      chk_cnt++;
      if ({got[i].sp, got[i].inv, got[i].res} !== e || got[i].a !== acc[i].a ||
          got[i].b !== acc[i].b || got[i].op !== acc[i].op || got[i].tag !== acc[i].tag)
        $display("FAIL rnd%0d got %h a=%h b=%h op=%0d tag=%0d want %h a=%h b=%h op=%0d tag=%0d",
                 i, {got[i].sp, got[i].inv, got[i].res}, got[i].a, got[i].b,
                 got[i].op, got[i].tag, e, acc[i].a, acc[i].b, acc[i].op, acc[i].tag);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    got.delete(); acc.delete();
    out_ready = 1'b0;
    in_a = 32'h3F800000; in_b = 32'h00000000; in_op = 2'b10;
    in_valid = 1'b1; in_tag = 4'd5;
    tick();
    in_tag = 4'd6;
    tick();
    in_tag = 4'd7; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL fl_two got valid=%b ready=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (4) tick();
    chk_cnt++;
    if (got.size() != 0) $display("FAIL fl_two_drop got %0d outputs want 0", got.size());
    else pass_cnt++;

    got.delete(); acc.delete();
    in_valid = 1'b1; in_tag = 4'd8;
    tick();
    in_tag = 4'd9; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL fl_one got valid=%b want 0", out_valid);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if (got.size() != 1 || got[0].tag !== 4'd8)
      $display("FAIL fl_one_pop got %0d outputs first tag %0d want 1 output tag 8",
               got.size(), got.size() > 0 ? got[0].tag : 4'd0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    got.delete(); acc.delete();
    out_ready = 1'b0;
    in_a = 32'h7F800000; in_b = 32'h3F800000; in_op = 2'b00;
    in_valid = 1'b1; in_tag = 4'd10;
    tick();
    in_tag = 4'd11;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 4'd0)
      $display("FAIL rmid got valid=%b ready=%b tag=%0d want 0 1 0",
               out_valid, in_ready, out_tag);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_tag = 4'd12;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && got.size() == 0; i++) tick();
    repeat (2) tick();
    chk_cnt++;
    if (got.size() != 1 || got[0].tag !== 4'd12)
      $display("FAIL rmid_after got %0d outputs first tag %0d want 1 output tag 12",
               got.size(), got.size() > 0 ? got[0].tag : 4'd0);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    test_reset();
    test_special();
    test_backpressure();
    test_throughput();
    test_random();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
